// File: rtl/aes_block_sequencer_if.sv
// Handshake and bus bundle between the block sequencer and its environment:
// input buffer, cipher-core issue/return and result buffer.
interface aes_block_sequencer_if #(
  parameter int DATA_W = 4096,
  parameter int BLK_W  = 128
);
  localparam int NBLK = DATA_W / BLK_W;
  localparam int CW   = $clog2(NBLK + 1);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CW-1:0]     in_nblk;

  logic              blk_valid;
  logic              blk_ready;
  logic [BLK_W-1:0]  blk_data;
  logic [CW-2:0]     blk_idx;

  logic              res_valid;
  logic [BLK_W-1:0]  res_data;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              err;

  modport slave (
    input  in_valid, in_data, in_nblk,
    input  blk_ready, res_valid, res_data,
    input  out_ready,
    output in_ready, blk_valid, blk_data, blk_idx,
    output out_valid, out_data, err
  );

  modport master (
    output in_valid, in_data, in_nblk,
    output blk_ready, res_valid, res_data,
    output out_ready,
    input  in_ready, blk_valid, blk_data, blk_idx,
    input  out_valid, out_data, err
  );
endinterface

// File: rtl/aes_block_sequencer.sv
// Splits a wide buffer into cipher blocks, issues them to a core and
// reassembles the in-order results into a wide output buffer.
module aes_block_sequencer #(
  parameter int DATA_W = 4096,
  parameter int BLK_W  = 128
) (
  input logic                  clk,
  input logic                  rst_n,
  aes_block_sequencer_if.slave bus
);
  localparam int NBLK = DATA_W / BLK_W;
  localparam int CW   = $clog2(NBLK + 1);
  localparam logic [CW-1:0] NBLK_C = CW'(NBLK);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_out;
  logic [CW-1:0]     r_n;
  logic [CW-1:0]     r_iss;
  logic [CW-1:0]     r_ret;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_err;
  logic              r_blank;

  logic [CW-2:0]     w_idx;
  logic [CW-1:0]     w_n_in;
  logic              w_blk_valid;
  logic              w_issue;
  logic              w_in_hs;
  logic              w_res_ok;
  logic              w_res_bad;

  assign w_idx       = r_iss[CW-2:0];
  assign w_n_in      = (bus.in_nblk == '0 || bus.in_nblk > NBLK_C)
                     ? NBLK_C : bus.in_nblk;
  assign w_blk_valid = (r_state == RUN) && (r_iss < r_n);
  assign w_issue     = w_blk_valid && bus.blk_ready;
  assign w_in_hs     = bus.in_valid && r_in_ready;
  // A result may only retire a block issued in an earlier cycle.
  assign w_res_ok    = bus.res_valid && (r_state == RUN)
                     && (r_ret < r_iss) && !r_blank;
  assign w_res_bad   = bus.res_valid && !r_blank && !w_res_ok;

  assign bus.in_ready  = r_in_ready;
  assign bus.blk_valid = w_blk_valid;
  assign bus.blk_data  = r_data[w_idx*BLK_W +: BLK_W];
  assign bus.blk_idx   = w_idx;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out;
  assign bus.err       = r_err;

  always_ff @(posedge clk) begin
    if (w_in_hs) begin
      r_data <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_out       <= '0;
      r_n         <= '0;
      r_iss       <= '0;
      r_ret       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_blank     <= 1'b1;
    end else begin
      r_blank <= 1'b0;
      if (w_res_bad) begin
        r_err <= 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (w_in_hs) begin
            r_n        <= w_n_in;
            r_iss      <= '0;
            r_ret      <= '0;
            r_out      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          if (w_issue) begin
            r_iss <= r_iss + 1'b1;
          end
          if (w_res_ok) begin
            r_out[r_ret*BLK_W +: BLK_W] <= bus.res_data;
            r_ret <= r_ret + 1'b1;
            if (r_ret + 1'b1 == r_n) begin
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
